// File: rtl/keypad_matrix_scan.sv
// keypad_matrix_scan
//   Scans a 4x4 membrane keypad one column at a time, assembles a 16-bit
//   snapshot per scan frame, debounces it over DB_FRAMES identical frames
//   and presents a one-hot key code (bit = col*4 + row).
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   row_n[3:0] keypad rows, active-low, asynchronous to clk
//   col_n[3:0] column drive, active-low, exactly one bit low
//   onehot     debounced key code, 0 = no key or multiple keys
//   key_valid  one-cycle pulse when onehot takes a new nonzero value
module keypad_matrix_scan #(
  parameter int SCAN_DIV  = 50000,  // clocks per column dwell, >= 4
  parameter int DB_FRAMES = 4       // identical frames to accept, >= 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic [15:0] onehot,
  output logic        key_valid
);

  localparam int DW     = $clog2(SCAN_DIV);
  localparam int CW     = $clog2(DB_FRAMES);
  localparam int STAGES = 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DB_FRAMES - 1);

  logic [3:0]        row_meta, row_sync;
  logic [DW-1:0]     dwell;
  logic [1:0]        col;
  logic [15:0]       acc, snap, prev;
  logic [CW-1:0]     stable_cnt, cnt_next;
  logic [STAGES:0]   vld_pipe;   // [0]: load snapshot, [1]: debounce eval
  logic              accept;
  logic              sample, frame_end;
  logic [15:0]       cand;

  // Two-flop synchronizer; idles high like the pulled-up rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
    end
  end

  assign sample    = (dwell == DWELL_LAST);
  assign frame_end = sample && (col == 2'd3);
  assign col_n     = ~(4'b0001 << col);

  // Column scan and frame accumulation. Rows are sampled at the end of the
  // dwell so the synchronizer has settled on the current column's rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell <= '0;
      col   <= '0;
      acc   <= '0;
    end else begin
      if (sample) begin
        dwell              <= '0;
        col                <= col + 2'd1;
        acc[col*4 +: 4]    <= ~row_sync;
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  // Frame-level pipeline: snapshot, then debounce evaluation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:0], frame_end};
  end

  always_comb begin
    cnt_next = stable_cnt;
    if (snap == prev) begin
      if (stable_cnt != CNT_MAX) cnt_next = stable_cnt + CW'(1);
    end else begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap       <= '0;
      prev       <= '0;
      stable_cnt <= '0;
      accept     <= 1'b0;
    end else begin
      accept <= 1'b0;
      if (vld_pipe[0]) snap <= acc;
      if (vld_pipe[1]) begin
        stable_cnt <= cnt_next;
        prev       <= snap;
        accept     <= (cnt_next == CNT_MAX);
      end
    end
  end

  // Only a single pressed key yields a code; ghosting/multi-key gives 0.
  assign cand = ($countones(snap) == 1) ? snap : 16'h0000;

  // Re-acceptance of an unchanged value leaves onehot alone and does not
  // pulse; a change to zero updates onehot silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot    <= '0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (accept) begin
        onehot    <= cand;
        key_valid <= (cand != 16'h0000) && (cand != onehot);
      end
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Bench for keypad_matrix_scan: a keypad matrix model drives the rows from
// the set of pressed keys; a frame-level reference model predicts onehot and
// the number of key_valid pulses.
module tb_keypad_matrix_scan;
  localparam int SD = 4;
  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_n, col_n;
  logic [15:0] onehot;
  logic        key_valid;
  logic [15:0] keys = 16'h0000;

  int n_chk = 0, n_pass = 0;
  int pulses = 0, exp_pulses = 0;

  // reference model state (frame level)
  logic [15:0] m_last, m_exp, m_keys;
  int          m_run;

  keypad_matrix_scan #(.SCAN_DIV(SD), .DB_FRAMES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
    .onehot(onehot), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  // pressed key at (c,r) pulls row r low while column c is driven low
  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (col_n[c] == 1'b0 && keys[c*4+r]) row_n[r] = 1'b0;
  end

  always @(negedge clk) if (rst_n && key_valid) pulses++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_last = 16'h0000;
    m_run  = 1;
    m_exp  = 16'h0000;
  endtask

  // one scan frame whose snapshot is s
  task automatic model_frame(input logic [15:0] s);
    logic [15:0] cand;
    if (s == m_last) m_run++; else m_run = 1;
    m_last = s;
    if (m_run >= DB) begin
      cand = ($countones(s) == 1) ? s : 16'h0000;
      if (cand != 0 && cand != m_exp) exp_pulses++;
      m_exp = cand;
    end
  endtask

  // Wait for the next frame start, account for the frame that just ended,
  // apply new keys, then check outputs once the pipeline has settled.
  task automatic frame(input logic [15:0] k, input string tag);
    int t = 0;
    while (col_n !== 4'b0111 && t < 40) begin @(negedge clk); t++; end
    while (col_n === 4'b0111 && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) chk({tag, ".sync_timeout"}, 0, 1);
    model_frame(m_keys);
    keys   = k;
    m_keys = k;
    repeat (8) @(negedge clk);
    chk({tag, ".onehot"}, onehot, m_exp);
    chk({tag, ".pulses"}, pulses, exp_pulses);
  endtask

  task automatic hold(input logic [15:0] k, input int n, input string tag);
    for (int i = 0; i < n; i++) frame(k, tag);
  endtask

  initial begin
    logic [15:0] k;
    int sel, len;
    model_reset();
    m_keys = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst.col_n", col_n, 4'b1110);
    chk("rst.onehot", onehot, 0);
    chk("rst.key_valid", key_valid, 0);
    rst_n = 1'b1;

    // idle scan: column rotation and quiet outputs for 20 frames
    for (int i = 0; i < 20 * 4 * SD; i++) begin
      k = ~(16'h0001 << ((i / SD) % 4));
      if (col_n !== k[3:0]) chk("idle.col_n", col_n, k[3:0]);
      if ((i % 16) == 15) begin
        chk("idle.onehot", onehot, 0);
        chk("idle.pulses", pulses, 0);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 20; i++) model_frame(16'h0000);

    hold(16'h0040, 4, "press_c1r2");
    chk("press_c1r2.code", onehot, 16'h0040);
    hold(16'h0040, 10, "held_c1r2");
    chk("held_c1r2.one_pulse", pulses, 1);
    hold(16'h0000, 3, "release");

    for (int i = 0; i < 5; i++) begin
      frame(16'h0040, "bounce_on");
      frame(16'h0000, "bounce_off");
    end
    chk("bounce.no_code", onehot, 0);

    hold(16'h8008, 4, "two_keys");
    chk("two_keys.zero", onehot, 0);
    hold(16'h0008, 4, "drop_c3r3");
    chk("drop_c3r3.code", onehot, 16'h0008);
    hold(16'h0000, 3, "release2");

    hold(16'h2000, 4, "key_a");
    hold(16'h4000, 4, "key_b");
    chk("a_to_b.code", onehot, 16'h4000);
    hold(16'h0000, 4, "release_b");

    // reset in the middle of a frame while a code is held
    hold(16'h0800, 4, "pre_reset");
    chk("pre_reset.code", onehot, 16'h0800);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.onehot", onehot, 0);
    chk("midrst.key_valid", key_valid, 0);
    chk("midrst.col_n", col_n, 4'b1110);
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    hold(16'h0800, 4, "post_reset");
    chk("post_reset.code", onehot, 16'h0800);

    // randomized key sequences
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       k = 16'h0000;
        3:       k = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
        default: k = 16'h0001 << $urandom_range(0, 15);
      endcase
      len = $urandom_range(1, 4);
      hold(k, len, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
